opb_reg_bank: RTL
=================

Name: opb_reg_bank

Overview:
- OPB slave sitting directly downstream of the OPB emulation target.
- Consumes OPB_ADDR/OPB_DO/OPB_RE/OPB_WE driven by the message-driven master.
- Returns OPB_DI exactly one SYS_CLK after OPB_RE, which the master's 1-clk-delayed read capture expects.
- Provides an ID register, scratch registers, a 2 kHz tick counter, W1C status, a control output register and a 32-bit loopback FIFO for link/bring-up testing over the message channel.

Parameters:
- BASE_ADDR, 24'h000000: block selected when OPB_ADDR[31:8] == BASE_ADDR.
- FIFO_DEPTH, 16: loopback FIFO depth in words. Power of two, 2..32.
- ID_VALUE, 32'h4750_4201: constant returned by the ID register.

Ports:
- SYS_CLK  in  1  system clock.
- SYS_RST  in  1  asynchronous, active-high reset.
- PULSE_2KHZ  in  1  2 kHz pulse, synchronous to SYS_CLK.
- OPB_ADDR  in  32  byte address from master; word-aligned, OPB_ADDR[1:0] ignored.
- OPB_DO  in  32  write data from master.
- OPB_RE  in  1  single-cycle read strobe.
- OPB_WE  in  1  single-cycle write strobe.
- OPB_DI  out  32  read data to master.
- CTRL_OUT  out  32  CTRL register contents.
- IRQ  out  1  OR of all STATUS sticky bits, registered.

Behaviour:
- Reset: all registers, FIFO pointers and level, sticky bits and the tick counter clear to 0. OPB_DI=0, CTRL_OUT=0, IRQ=0.
- Access decode: an access is valid when (OPB_RE xor OPB_WE) and OPB_ADDR[31:8]==BASE_ADDR. Offset is OPB_ADDR[7:0].
- Both strobes in the same cycle: no access performed, STATUS.proto_err (bit3) set, OPB_DI unchanged.
- Strobes with a non-matching base: ignored entirely, no OPB_DI update, no flags set.
- Read latency: OPB_DI is registered and updated on the clock edge after OPB_RE. It holds that value until the next valid read.
- Register map (offset, access, function):
  - 0x00 ID, RO: returns ID_VALUE.
  - 0x04 SCRATCH0, RW: reset 0.
  - 0x08 SCRATCH1, RW: reset 0.
  - 0x0C TICK, RO: free-running 32-bit counter of PULSE_2KHZ rising edges, detected against a registered copy of the input. Wraps 0xFFFFFFFF->0. Any write clears it to 0; clear wins over a same-cycle increment.
  - 0x10 STATUS: bit0 fifo_ovf W1C, bit1 fifo_udf W1C, bit2 unmapped W1C, bit3 proto_err W1C, bits[13:8] fifo level RO (0..FIFO_DEPTH), others read 0. A same-cycle set event wins over W1C.
  - 0x14 FIFO: a write pushes OPB_DO; a read pops and returns the head word.
  - 0x18 CTRL, RW: drives CTRL_OUT. Bit31 is flush, self-clearing: the written 1 empties the FIFO that cycle, and bit31 always reads and outputs 0.
  - Any other offset: read returns 32'hDEAD_BEEF; read or write sets STATUS.unmapped; writes have no effect.
- FIFO boundaries:
  - Push when full: word dropped, fifo_ovf set, level stays FIFO_DEPTH.
  - Pop when empty: returns 32'h0, fifo_udf set, pointers unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - A flush in the same cycle as a push cannot occur (single access per cycle). Flush takes effect at the CTRL write edge, and a pop on the next cycle sees empty.
  - Level updates on the access edge, so a STATUS read immediately after a push shows the incremented level.
- IRQ is registered: it rises the cycle after any sticky bit is set and falls the cycle after the last sticky bit is cleared.
- Reset mid-operation: asynchronous return to reset values. FIFO contents are lost; level and pointers read 0.

Decomposition:
- Package opb_reg_bank_pkg holds:
  - offset constants: OFS_ID, OFS_SCRATCH0, OFS_SCRATCH1, OFS_TICK, OFS_STATUS, OFS_FIFO, OFS_CTRL;
  - STATUS bit indices;
  - UNMAPPED_RDATA = 32'hDEAD_BEEF;
  - CTRL_FLUSH_BIT = 31.
- One sub-module, sync_fifo32 (parameter DEPTH): single-clock 32-bit FIFO with push, pop, flush, full, empty and level outputs, async reset. Decode, registers and read mux stay in the top module.

Test Plan:
- Reset, then read 0x00 -> OPB_DI=32'h4750_4201 one clock after OPB_RE; read 0x04 -> 0; IRQ=0.
- Write 0x04=32'hA5A5_1234, write 0x08=32'h0000_FFFF; read both back -> same values, each exactly 1 clk after RE, then held.
- Push 16 words 1..16 to 0x14, push 17th -> STATUS=32'h0000_1001 (level 16, ovf) and IRQ=1. Pop 16 -> 1..16 in order. Pop again -> 0 and udf set. Write STATUS=32'hF -> STATUS=0 and IRQ=0 next cycle.
- Apply 5 PULSE_2KHZ pulses -> TICK=5. Write 0x0C coincident with a pulse -> TICK=0. Preload the counter to 0xFFFFFFFF and pulse -> 0.
- Push 3 words, then write CTRL=32'h8000_0003 -> CTRL_OUT=32'h0000_0003, level 0, next pop sets udf.
- Read 0x40 -> 32'hDEAD_BEEF and unmapped set. RE+WE same cycle -> proto_err set, no register change. Access with OPB_ADDR[31:8]!=BASE_ADDR -> no effect. Assert SYS_RST mid-sequence -> all outputs 0 immediately.

Source files
------------

// File: rtl/opb_reg_bank_pkg.sv
// rtl/opb_reg_bank_pkg.sv - register offsets, STATUS layout and shared constants for opb_reg_bank
package opb_reg_bank_pkg;

   localparam logic [7:0] OFS_ID       = 8'h00;
   localparam logic [7:0] OFS_SCRATCH0 = 8'h04;
   localparam logic [7:0] OFS_SCRATCH1 = 8'h08;
   localparam logic [7:0] OFS_TICK     = 8'h0C;
   localparam logic [7:0] OFS_STATUS   = 8'h10;
   localparam logic [7:0] OFS_FIFO     = 8'h14;
   localparam logic [7:0] OFS_CTRL     = 8'h18;

   localparam int ST_FIFO_OVF  = 0;
   localparam int ST_FIFO_UDF  = 1;
   localparam int ST_UNMAPPED  = 2;
   localparam int ST_PROTO_ERR = 3;
   localparam int ST_STICKY_W  = 4;
   localparam int ST_LEVEL_LSB = 8;
   localparam int ST_LEVEL_W   = 6;

   localparam logic [31:0] UNMAPPED_RDATA = 32'hDEAD_BEEF;
   localparam int          CTRL_FLUSH_BIT = 31;

   function automatic logic [31:0] pack_status(input logic [ST_STICKY_W-1:0] sticky,
                                               input logic [ST_LEVEL_W-1:0]  level);
      logic [31:0] word;
      word = '0;
      word[ST_STICKY_W-1:0] = sticky;
      word[ST_LEVEL_LSB +: ST_LEVEL_W] = level;
      return word;
   endfunction

endpackage

// File: rtl/opb_reg_bank_sync_fifo32.sv
// rtl/opb_reg_bank_sync_fifo32.sv - single-clock 32-bit FIFO with flush and level, async reset
module sync_fifo32 #(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [31:0]              push_data,
   input  logic                     pop,
   input  logic                     flush,
   output logic [31:0]              head_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [31:0]      mem_q [DEPTH];
   logic [31:0]      mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             do_push;
   logic             do_pop;

   assign full      = (level_q == LVL_W'(DEPTH));
   assign empty     = (level_q == '0);
   assign level     = level_q;
   assign head_data = mem_q[rd_ptr_q];
   assign do_push   = push & ~full;
   assign do_pop    = pop & ~empty;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

endmodule

// File: rtl/opb_reg_bank.sv
// rtl/opb_reg_bank.sv - OPB slave register bank: ID, scratch, 2 kHz tick, W1C status, control, loopback FIFO
module opb_reg_bank
   import opb_reg_bank_pkg::*;
#(
   parameter logic [23:0] BASE_ADDR  = 24'h000000,
   parameter int          FIFO_DEPTH = 16,
   parameter logic [31:0] ID_VALUE   = 32'h4750_4201
) (
   input  logic        SYS_CLK,
   input  logic        SYS_RST,
   input  logic        PULSE_2KHZ,
   input  logic [31:0] OPB_ADDR,
   input  logic [31:0] OPB_DO,
   input  logic        OPB_RE,
   input  logic        OPB_WE,
   output logic [31:0] OPB_DI,
   output logic [31:0] CTRL_OUT,
   output logic        IRQ
);

   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

   logic [31:0]            rdata_q, rdata_d;
   logic [31:0]            scratch0_q, scratch0_d;
   logic [31:0]            scratch1_q, scratch1_d;
   logic [31:0]            tick_q, tick_d;
   logic [31:0]            ctrl_q, ctrl_d;
   logic [ST_STICKY_W-1:0] status_q, status_d;
   logic                   pulse_q, pulse_d;
   logic                   irq_q, irq_d;

   logic                   base_hit, rd_acc, wr_acc, both_acc;
   logic [7:0]             ofs;
   logic                   mapped;
   logic [ST_STICKY_W-1:0] status_set, status_clr;
   logic                   fifo_push, fifo_pop, fifo_flush;
   logic                   fifo_full, fifo_empty;
   logic [31:0]            fifo_head;
   logic [LVL_W-1:0]       fifo_level;
   logic                   unused_addr_lsbs;

   assign unused_addr_lsbs = ^OPB_ADDR[1:0];

   sync_fifo32 #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (SYS_CLK),
      .rst       (SYS_RST),
      .push      (fifo_push),
      .push_data (OPB_DO),
      .pop       (fifo_pop),
      .flush     (fifo_flush),
      .head_data (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

   // Only one decoded access per cycle; RE and WE together is a protocol error, not an access.
   always_comb begin
      base_hit = (OPB_ADDR[31:8] == BASE_ADDR);
      rd_acc   = base_hit & OPB_RE & ~OPB_WE;
      wr_acc   = base_hit & OPB_WE & ~OPB_RE;
      both_acc = base_hit & OPB_RE & OPB_WE;
      ofs      = {OPB_ADDR[7:2], 2'b00};
      mapped   = (ofs == OFS_ID)     || (ofs == OFS_SCRATCH0) || (ofs == OFS_SCRATCH1) ||
                 (ofs == OFS_TICK)   || (ofs == OFS_STATUS)   || (ofs == OFS_FIFO)     ||
                 (ofs == OFS_CTRL);

      fifo_push  = wr_acc & (ofs == OFS_FIFO) & ~fifo_full;
      fifo_pop   = rd_acc & (ofs == OFS_FIFO) & ~fifo_empty;
      fifo_flush = wr_acc & (ofs == OFS_CTRL) & OPB_DO[CTRL_FLUSH_BIT];

      status_set               = '0;
      status_set[ST_FIFO_OVF]  = wr_acc & (ofs == OFS_FIFO) & fifo_full;
      status_set[ST_FIFO_UDF]  = rd_acc & (ofs == OFS_FIFO) & fifo_empty;
      status_set[ST_UNMAPPED]  = (rd_acc | wr_acc) & ~mapped;
      status_set[ST_PROTO_ERR] = both_acc;
      status_clr = (wr_acc && ofs == OFS_STATUS) ? OPB_DO[ST_STICKY_W-1:0] : '0;
      status_d   = (status_q & ~status_clr) | status_set;

      irq_d   = |status_q;
      pulse_d = PULSE_2KHZ;

      tick_d = tick_q;
      if (wr_acc && ofs == OFS_TICK) begin
         tick_d = '0;
      end else if (PULSE_2KHZ && !pulse_q) begin
         tick_d = tick_q + 32'd1;
      end

      scratch0_d = scratch0_q;
      scratch1_d = scratch1_q;
      ctrl_d     = ctrl_q;
      if (wr_acc) begin
         case (ofs)
            OFS_SCRATCH0: scratch0_d = OPB_DO;
            OFS_SCRATCH1: scratch1_d = OPB_DO;
            OFS_CTRL: begin
               ctrl_d                 = OPB_DO;
               ctrl_d[CTRL_FLUSH_BIT] = 1'b0;
            end
            default: ;
         endcase
      end

      rdata_d = rdata_q;
      if (rd_acc) begin
         case (ofs)
            OFS_ID:       rdata_d = ID_VALUE;
            OFS_SCRATCH0: rdata_d = scratch0_q;
            OFS_SCRATCH1: rdata_d = scratch1_q;
            OFS_TICK:     rdata_d = tick_q;
            OFS_STATUS:   rdata_d = pack_status(status_q, ST_LEVEL_W'(fifo_level));
            OFS_FIFO:     rdata_d = fifo_empty ? 32'h0 : fifo_head;
            OFS_CTRL:     rdata_d = ctrl_q;
            default:      rdata_d = UNMAPPED_RDATA;
         endcase
      end
   end

   always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
      if (SYS_RST) begin
         rdata_q    <= '0;
         scratch0_q <= '0;
         scratch1_q <= '0;
         tick_q     <= '0;
         ctrl_q     <= '0;
         status_q   <= '0;
         pulse_q    <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         rdata_q    <= rdata_d;
         scratch0_q <= scratch0_d;
         scratch1_q <= scratch1_d;
         tick_q     <= tick_d;
         ctrl_q     <= ctrl_d;
         status_q   <= status_d;
         pulse_q    <= pulse_d;
         irq_q      <= irq_d;
      end
   end

   assign OPB_DI   = rdata_q;
   assign CTRL_OUT = ctrl_q;
   assign IRQ      = irq_q;

endmodule
